// File: rtl/sorc_kbd_pkg.sv
// -----------------------------------------------------------------------------
// sorc_kbd_pkg
// Shared constants, types and the PS/2 set-2 to Sorcerer matrix key map.
//   KBD_ROWS / KBD_COLS : default matrix geometry
//   kbd_loc_t           : {hit, row, col} result of a key-map lookup
//   lookup()            : {ext, code} -> kbd_loc_t (hit=0 for unmapped keys)
//   SHIFT, CTRL, RETURN : named matrix locations
// -----------------------------------------------------------------------------
package sorc_kbd_pkg;

   localparam int KBD_ROWS = 16;
   localparam int KBD_COLS = 8;

   typedef struct packed {
      logic       hit;
      logic [3:0] row;
      logic [2:0] col;
   } kbd_loc_t;

   localparam kbd_loc_t SHIFT  = '{hit: 1'b1, row: 4'd0, col: 3'd0};
   localparam kbd_loc_t CTRL   = '{hit: 1'b1, row: 4'd0, col: 3'd1};
   localparam kbd_loc_t RETURN = '{hit: 1'b1, row: 4'd1, col: 3'd0};

   // {ext, code} values that get special handling in the pipeline
   localparam logic [8:0] CODE_LSHIFT = 9'h012;
   localparam logic [8:0] CODE_RSHIFT = 9'h059;
   localparam logic [8:0] CODE_F11    = 9'h078;

   function automatic kbd_loc_t loc_at(input logic [3:0] row, input logic [2:0] col);
      return '{hit: 1'b1, row: row, col: col};
   endfunction

   // Every location is owned by exactly one code, except SHIFT which both
   // shift keys share (their OR is resolved in the matrix stage).
   function automatic kbd_loc_t lookup(input logic [8:0] ext_code);
      kbd_loc_t loc;
      loc = '0;
      case (ext_code)
         CODE_LSHIFT, CODE_RSHIFT: loc = SHIFT;
         9'h014: loc = CTRL;
         9'h076: loc = loc_at(4'd0, 3'd2);   // ESC
         9'h029: loc = loc_at(4'd0, 3'd3);   // SPACE
         9'h066: loc = loc_at(4'd0, 3'd4);   // BACKSPACE
         9'h00D: loc = loc_at(4'd0, 3'd5);   // TAB
         9'h05A: loc = RETURN;
         9'h041: loc = loc_at(4'd1, 3'd1);   // ,
         9'h049: loc = loc_at(4'd1, 3'd2);   // .
         9'h01C: loc = loc_at(4'd2, 3'd0);   // A
         9'h032: loc = loc_at(4'd2, 3'd1);   // B
         9'h021: loc = loc_at(4'd2, 3'd2);   // C
         9'h023: loc = loc_at(4'd2, 3'd3);   // D
         9'h024: loc = loc_at(4'd2, 3'd4);   // E
         9'h02B: loc = loc_at(4'd2, 3'd5);   // F
         9'h034: loc = loc_at(4'd2, 3'd6);   // G
         9'h033: loc = loc_at(4'd2, 3'd7);   // H
         9'h043: loc = loc_at(4'd3, 3'd0);   // I
         9'h03B: loc = loc_at(4'd3, 3'd1);   // J
         9'h042: loc = loc_at(4'd3, 3'd2);   // K
         9'h04B: loc = loc_at(4'd3, 3'd3);   // L
         9'h03A: loc = loc_at(4'd3, 3'd4);   // M
         9'h031: loc = loc_at(4'd3, 3'd5);   // N
         9'h044: loc = loc_at(4'd3, 3'd6);   // O
         9'h04D: loc = loc_at(4'd3, 3'd7);   // P
         9'h015: loc = loc_at(4'd4, 3'd0);   // Q
         9'h02D: loc = loc_at(4'd4, 3'd1);   // R
         9'h01B: loc = loc_at(4'd4, 3'd2);   // S
         9'h02C: loc = loc_at(4'd4, 3'd3);   // T
         9'h175: loc = loc_at(4'd7, 3'd0);   // cursor up
         9'h172: loc = loc_at(4'd7, 3'd1);   // cursor down
         9'h16B: loc = loc_at(4'd7, 3'd2);   // cursor left
         9'h174: loc = loc_at(4'd7, 3'd3);   // cursor right
         default: loc = '0;
      endcase
      return loc;
   endfunction

endpackage

// File: rtl/sorc_kbd_sync.sv
// -----------------------------------------------------------------------------
// sorc_kbd_sync
// Two-flop bus synchroniser for the row select coming from the core clock
// domain; EN=0 turns it into a plain wire.
//   clk_sys : system clock            reset : async, active-high
//   i_d     : asynchronous bus in     o_q   : synchronised bus out
// -----------------------------------------------------------------------------
module sorc_kbd_sync #(
   parameter int WIDTH = 4,
   parameter bit EN    = 1'b1
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   generate
      if (EN) begin : g_sync
         logic [WIDTH-1:0] r_meta;
         logic [WIDTH-1:0] r_sync;

         always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
               r_meta <= '0;
               r_sync <= '0;
            end else begin
               r_meta <= i_d;
               r_sync <= r_meta;
            end
         end

         assign o_q = r_sync;
      end else begin : g_bypass
         assign o_q = i_d;
      end
   endgenerate

endmodule

// File: rtl/sorc_kbd_matrix.sv
// -----------------------------------------------------------------------------
// sorc_kbd_matrix
// Turns hps_io ps2_key events into the Sorcerer 16x8 keyboard matrix.
// Pipeline: S1 capture strobe edge -> S2 key-map lookup -> S3 matrix update,
// then a registered column read of the row selected by the core.
// Ports:
//   clk_sys   : system clock              reset   : async, active-high
//   ps2_key   : [10] toggle, [9] pressed, [8] extended, [7:0] scan code
//   kbd_clear : level, releases every key while high
//   row_sel   : row scanned by the core   col_n   : selected row, active low
//   any_key   : some key is down          hotkey  : 1-cycle F11 press pulse
// Build option: define SORC_KBD_HOTKEY_EN to turn F11 into the hotkey pulse;
// otherwise hotkey is tied low and F11 is an unmapped key.
// -----------------------------------------------------------------------------
module sorc_kbd_matrix
   import sorc_kbd_pkg::*;
#(
   parameter int ROWS     = KBD_ROWS,
   parameter int COLS     = KBD_COLS,
   parameter int SYNC_ROW = 1
) (
   input  logic            clk_sys,
   input  logic            reset,
   input  logic [10:0]     ps2_key,
   input  logic            kbd_clear,
   input  logic [3:0]      row_sel,
   output logic [COLS-1:0] col_n,
   output logic            any_key,
   output logic            hotkey
);

   logic [3:0] w_row_s;

   sorc_kbd_sync #(
      .WIDTH (4),
      .EN    (SYNC_ROW != 0)
   ) u_row_sync (
      .clk_sys (clk_sys),
      .reset   (reset),
      .i_d     (row_sel),
      .o_q     (w_row_s)
   );

   // ---------------- S1: capture ----------------
   // r_primed keeps the first clock after reset from seeing a phantom edge.
   logic       r_primed;
   logic       r_strobe;
   logic       r_valid_1;
   logic       r_pressed_1;
   logic [8:0] r_code_1;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_primed    <= 1'b0;
         r_strobe    <= 1'b0;
         r_valid_1   <= 1'b0;
         r_pressed_1 <= 1'b0;
         r_code_1    <= '0;
      end else begin
         r_primed    <= 1'b1;
         r_strobe    <= ps2_key[10];
         r_valid_1   <= r_primed & (ps2_key[10] != r_strobe);
         r_pressed_1 <= ps2_key[9];
         r_code_1    <= ps2_key[8:0];
      end
   end

   // ---------------- S2: lookup ----------------
   kbd_loc_t r_loc_2;
   logic     r_valid_2;
   logic     r_pressed_2;
   logic     r_shl_2;
   logic     r_shr_2;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_loc_2     <= '0;
         r_valid_2   <= 1'b0;
         r_pressed_2 <= 1'b0;
         r_shl_2     <= 1'b0;
         r_shr_2     <= 1'b0;
      end else begin
         r_loc_2     <= lookup(r_code_1);
         r_valid_2   <= r_valid_1;
         r_pressed_2 <= r_pressed_1;
         r_shl_2     <= (r_code_1 == CODE_LSHIFT);
         r_shr_2     <= (r_code_1 == CODE_RSHIFT);
      end
   end

   // ---------------- S3: apply ----------------
   // The two shift keys are tracked separately so that releasing one while
   // the other is held leaves SHIFT down; the SHIFT matrix cell itself stays 0.
   logic [COLS-1:0] r_matrix [16];
   logic            r_shl;
   logic            r_shr;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) r_matrix[i] <= '0;
         r_shl <= 1'b0;
         r_shr <= 1'b0;
      end else if (kbd_clear) begin
         for (int i = 0; i < 16; i++) r_matrix[i] <= '0;
         r_shl <= 1'b0;
         r_shr <= 1'b0;
      end else if (r_valid_2) begin
         if (r_shl_2)          r_shl <= r_pressed_2;
         else if (r_shr_2)     r_shr <= r_pressed_2;
         else if (r_loc_2.hit) r_matrix[r_loc_2.row][r_loc_2.col] <= r_pressed_2;
      end
   end

`ifdef SORC_KBD_HOTKEY_EN
   logic r_f11_2;
   logic r_hotkey;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_f11_2  <= 1'b0;
         r_hotkey <= 1'b0;
      end else begin
         r_f11_2  <= (r_code_1 == CODE_F11);
         r_hotkey <= r_valid_2 & r_f11_2 & r_pressed_2 & ~kbd_clear;
      end
   end

   assign hotkey = r_hotkey;
`else
   assign hotkey = 1'b0;
`endif

   // ---------------- column read ----------------
   logic            w_row_live;
   logic [COLS-1:0] w_sel;
   logic            w_any;

   generate
      if (ROWS < 16) begin : g_row_chk
         assign w_row_live = (w_row_s < 4'(ROWS));
      end else begin : g_row_all
         assign w_row_live = 1'b1;
      end
   endgenerate

   always_comb begin
      w_sel = r_matrix[w_row_s];
      if (w_row_s == SHIFT.row) w_sel[SHIFT.col] = w_sel[SHIFT.col] | r_shl | r_shr;
   end

   always_comb begin
      w_any = r_shl | r_shr;
      for (int i = 0; i < 16; i++) w_any = w_any | (|r_matrix[i]);
   end

   assign any_key = w_any;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) col_n <= '1;
      else       col_n <= w_row_live ? ~w_sel : '1;
   end

endmodule

// File: tb/tb_sorc_kbd_matrix.sv
// -----------------------------------------------------------------------------
// tb_sorc_kbd_matrix
// Self-checking bench for sorc_kbd_matrix. The reference model is a per-key
// "is down" table plus the key map listed below; expected columns are derived
// from which mapped keys are down, with the shift keys sharing one cell.
// -----------------------------------------------------------------------------
module tb_sorc_kbd_matrix;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] ps2_key = '0;
   logic        kbd_clear = 1'b0;
   logic [3:0]  row_sel = '0;
   logic [7:0]  col_n;
   logic        any_key;
   logic        hotkey;

   always #5 clk_sys = ~clk_sys;

   sorc_kbd_matrix u_dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ps2_key   (ps2_key),
      .kbd_clear (kbd_clear),
      .row_sel   (row_sel),
      .col_n     (col_n),
      .any_key   (any_key),
      .hotkey    (hotkey)
   );

   int total = 0;
   int bad   = 0;

   // Key map: {ext+code[8:0], row[3:0], col[2:0]}
   localparam int NMAP = 34;
   localparam logic [15:0] MAP [NMAP] = '{
      {9'h012, 4'd0, 3'd0}, {9'h059, 4'd0, 3'd0}, {9'h014, 4'd0, 3'd1},
      {9'h076, 4'd0, 3'd2}, {9'h029, 4'd0, 3'd3}, {9'h066, 4'd0, 3'd4},
      {9'h00D, 4'd0, 3'd5}, {9'h05A, 4'd1, 3'd0}, {9'h041, 4'd1, 3'd1},
      {9'h049, 4'd1, 3'd2}, {9'h01C, 4'd2, 3'd0}, {9'h032, 4'd2, 3'd1},
      {9'h021, 4'd2, 3'd2}, {9'h023, 4'd2, 3'd3}, {9'h024, 4'd2, 3'd4},
      {9'h02B, 4'd2, 3'd5}, {9'h034, 4'd2, 3'd6}, {9'h033, 4'd2, 3'd7},
      {9'h043, 4'd3, 3'd0}, {9'h03B, 4'd3, 3'd1}, {9'h042, 4'd3, 3'd2},
      {9'h04B, 4'd3, 3'd3}, {9'h03A, 4'd3, 3'd4}, {9'h031, 4'd3, 3'd5},
      {9'h044, 4'd3, 3'd6}, {9'h04D, 4'd3, 3'd7}, {9'h015, 4'd4, 3'd0},
      {9'h02D, 4'd4, 3'd1}, {9'h01B, 4'd4, 3'd2}, {9'h02C, 4'd4, 3'd3},
      {9'h175, 4'd7, 3'd0}, {9'h172, 4'd7, 3'd1}, {9'h16B, 4'd7, 3'd2},
      {9'h174, 4'd7, 3'd3}
   };
   // Codes with no matrix location (F1, F11, ext shift, `, keypad 8)
   localparam logic [8:0] UNMAPPED [5] = '{9'h005, 9'h078, 9'h112, 9'h00E, 9'h075};

   localparam logic [8:0] K_A = 9'h01C;
   localparam logic [8:0] K_B = 9'h032;
   localparam logic [8:0] K_C = 9'h021;
   localparam logic [8:0] K_LSH = 9'h012;
   localparam logic [8:0] K_RSH = 9'h059;
   localparam logic [8:0] K_F11 = 9'h078;

   bit key_down [512];
   bit strobe = 1'b0;
   int hot_high = 0;

   always @(negedge clk_sys) if (hotkey === 1'b1) hot_high <= hot_high + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic logic [7:0] exp_cols(input int r);
      logic [7:0]  v;
      logic [15:0] e;
      v = 8'hFF;
      for (int i = 0; i < NMAP; i++) begin
         e = MAP[i];
         if (int'(e[6:3]) == r && key_down[e[15:7]]) v[e[2:0]] = 1'b0;
      end
      return v;
   endfunction

   function automatic logic exp_any();
      logic [15:0] e;
      for (int i = 0; i < NMAP; i++) begin
         e = MAP[i];
         if (key_down[e[15:7]]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 512; i++) key_down[i] = 1'b0;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic drive_event(input bit p, input logic [8:0] c);
      strobe  = ~strobe;
      ps2_key = {strobe, p, c};
      if (!kbd_clear) key_down[c] = p;
   endtask

   task automatic send_event(input bit p, input logic [8:0] c);
      drive_event(p, c);
      tick();
   endtask

   task automatic drain();
      repeat (6) tick();
   endtask

   task automatic select_row(input int r);
      row_sel = 4'(r);
      repeat (4) tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) tick();
      reset = 1'b0;
      tick();
      total++;
      if (col_n !== 8'hFF || any_key !== 1'b0 || hotkey !== 1'b0) begin
         bad++;
         $display("FAIL reset_initial: col_n=%h any_key=%b hotkey=%b, want FF 0 0",
                  col_n, any_key, hotkey);
      end
      // build up state, then reset with an event still in the pipeline
      send_event(1'b1, K_A);
      send_event(1'b1, K_C);
      send_event(1'b1, K_LSH);
      drain();
      send_event(1'b1, K_B);
      #2 reset = 1'b1;
      model_clear();
      #1;
      total++;
      if (col_n !== 8'hFF || any_key !== 1'b0 || hotkey !== 1'b0) begin
         bad++;
         $display("FAIL reset_midrun: col_n=%h any_key=%b hotkey=%b, want FF 0 0",
                  col_n, any_key, hotkey);
      end
      repeat (2) tick();
      reset = 1'b0;
      drain();
      for (int r = 0; r < 16; r++) begin
         select_row(r);
         total++;
         if (col_n !== 8'hFF) begin
            bad++;
            $display("FAIL reset_row%0d: col_n=%h want FF", r, col_n);
         end
      end
      total++;
      if (any_key !== 1'b0) begin
         bad++;
         $display("FAIL reset_any_key: got %b want 0", any_key);
      end
   endtask

   task automatic test_latency();
      select_row(2);
      drive_event(1'b1, K_A);
      for (int k = 1; k <= 4; k++) begin
         tick();
         total++;
         if (col_n[0] !== (k < 4 ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL latency_press_clk%0d: col_n[0]=%b want %b", k, col_n[0], k >= 4 ? 0 : 1);
         end
      end
      drive_event(1'b0, K_A);
      for (int k = 1; k <= 4; k++) begin
         tick();
         total++;
         if (col_n[0] !== (k < 4 ? 1'b0 : 1'b1)) begin
            bad++;
            $display("FAIL latency_release_clk%0d: col_n[0]=%b want %b", k, col_n[0], k >= 4 ? 1 : 0);
         end
      end
      total++;
      if (col_n !== 8'hFF) begin
         bad++;
         $display("FAIL latency_final: col_n=%h want FF", col_n);
      end
   endtask

   task automatic test_shift();
      select_row(0);
      send_event(1'b1, K_LSH);
      drain();
      send_event(1'b1, K_RSH);
      drain();
      send_event(1'b0, K_LSH);
      drain();
      total++;
      if (col_n[0] !== 1'b0 || col_n !== exp_cols(0)) begin
         bad++;
         $display("FAIL shift_one_held: col_n=%h want %h (bit0=0)", col_n, exp_cols(0));
      end
      send_event(1'b0, K_RSH);
      drain();
      total++;
      if (col_n[0] !== 1'b1 || col_n !== exp_cols(0)) begin
         bad++;
         $display("FAIL shift_both_released: col_n=%h want %h (bit0=1)", col_n, exp_cols(0));
      end
   endtask

   task automatic test_back_to_back();
      select_row(2);
      send_event(1'b1, K_A);
      send_event(1'b1, K_B);
      send_event(1'b0, K_A);
      drain();
      total++;
      if (col_n !== 8'hFD || col_n !== exp_cols(2)) begin
         bad++;
         $display("FAIL b2b_row2: col_n=%h want FD", col_n);
      end
      total++;
      if (any_key !== 1'b1) begin
         bad++;
         $display("FAIL b2b_any_key: got %b want 1", any_key);
      end
      send_event(1'b0, K_B);
      drain();
      total++;
      if (col_n !== 8'hFF || any_key !== 1'b0) begin
         bad++;
         $display("FAIL b2b_release: col_n=%h any_key=%b want FF 0", col_n, any_key);
      end
   endtask

   task automatic test_clear();
      select_row(2);
      send_event(1'b1, K_A);
      drain();
      total++;
      if (col_n !== 8'hFE) begin
         bad++;
         $display("FAIL clear_held: col_n=%h want FE", col_n);
      end
      kbd_clear = 1'b1;
      tick();
      kbd_clear = 1'b0;
      model_clear();
      for (int r = 0; r < 16; r++) begin
         select_row(r);
         total++;
         if (col_n !== 8'hFF) begin
            bad++;
            $display("FAIL clear_row%0d: col_n=%h want FF", r, col_n);
         end
      end
      total++;
      if (any_key !== 1'b0) begin
         bad++;
         $display("FAIL clear_any_key: got %b want 0", any_key);
      end
      select_row(2);
      send_event(1'b0, K_A);
      drain();
      total++;
      if (col_n !== 8'hFF || any_key !== 1'b0) begin
         bad++;
         $display("FAIL clear_late_release: col_n=%h any_key=%b want FF 0", col_n, any_key);
      end
   endtask

   task automatic test_hotkey();
      int want;
`ifdef SORC_KBD_HOTKEY_EN
      want = 1;
`else
      want = 0;
`endif
      send_event(1'b1, K_C);
      drain();
      hot_high = 0;
      send_event(1'b1, K_F11);
      drain();
      total++;
      if (hot_high !== want) begin
         bad++;
         $display("FAIL hotkey_press: high cycles=%0d want %0d", hot_high, want);
      end
      send_event(1'b0, K_F11);
      drain();
      total++;
      if (hot_high !== want) begin
         bad++;
         $display("FAIL hotkey_release: high cycles=%0d want %0d", hot_high, want);
      end
      for (int r = 0; r < 8; r++) begin
         select_row(r);
         total++;
         if (col_n !== exp_cols(r)) begin
            bad++;
            $display("FAIL hotkey_row%0d: col_n=%h want %h", r, col_n, exp_cols(r));
         end
      end
      send_event(1'b0, K_C);
      drain();
   endtask

   task automatic test_random();
      logic [15:0] e;
      logic [8:0]  c;
      for (int b = 0; b < 6; b++) begin
         for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 4) == 0) begin
               c = UNMAPPED[$urandom_range(0, 4)];
            end else begin
               e = MAP[$urandom_range(0, NMAP - 1)];
               c = e[15:7];
            end
            send_event(1'($urandom_range(0, 1)), c);
            repeat ($urandom_range(0, 2)) tick();
         end
         drain();
         for (int r = 0; r < 16; r++) begin
            select_row(r);
            total++;
            if (col_n !== exp_cols(r)) begin
               bad++;
               $display("FAIL random_b%0d_row%0d: col_n=%h want %h", b, r, col_n, exp_cols(r));
            end
         end
         total++;
         if (any_key !== exp_any()) begin
            bad++;
            $display("FAIL random_b%0d_any_key: got %b want %b", b, any_key, exp_any());
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_latency();
      test_shift();
      test_back_to_back();
      test_clear();
      test_hotkey();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
